// File: rtl/vga_fb_arbiter_if.sv
// Bundles the timing-generator, RAM, scan-out and writer-client signals of vga_fb_arbiter.
// pattern_sel exists only when VGA_FB_TEST_PATTERN_EN is defined.
interface vga_fb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
) ();
    logic              blank_n;
    logic [10:0]       nextX;
    logic [9:0]        nextY;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pixel;
    logic              pixel_valid;
    logic              c0_req;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_data;
    logic              c0_gnt;
    logic              c1_req;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_data;
    logic              c1_gnt;
`ifdef VGA_FB_TEST_PATTERN_EN
    logic              pattern_sel;

    modport slave (
        input  blank_n, nextX, nextY, mem_rdata, pattern_sel,
        input  c0_req, c0_addr, c0_data, c1_req, c1_addr, c1_data,
        output mem_addr, mem_we, mem_wdata, pixel, pixel_valid, c0_gnt, c1_gnt
    );

    modport master (
        output blank_n, nextX, nextY, mem_rdata, pattern_sel,
        output c0_req, c0_addr, c0_data, c1_req, c1_addr, c1_data,
        input  mem_addr, mem_we, mem_wdata, pixel, pixel_valid, c0_gnt, c1_gnt
    );
`else
    modport slave (
        input  blank_n, nextX, nextY, mem_rdata,
        input  c0_req, c0_addr, c0_data, c1_req, c1_addr, c1_data,
        output mem_addr, mem_we, mem_wdata, pixel, pixel_valid, c0_gnt, c1_gnt
    );

    modport master (
        output blank_n, nextX, nextY, mem_rdata,
        output c0_req, c0_addr, c0_data, c1_req, c1_addr, c1_data,
        input  mem_addr, mem_we, mem_wdata, pixel, pixel_valid, c0_gnt, c1_gnt
    );
`endif
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port pixel RAM arbiter: display scan-out has absolute priority, two writers share the rest
// round-robin. Optional colour-bar source enabled by VGA_FB_TEST_PATTERN_EN.
module vga_fb_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 15,
    parameter int FB_W       = 200,
    parameter int SCALE_LOG2 = 2
) (
    input logic             Clock,
    input logic             Reset,
    vga_fb_arbiter_if.slave bus
);

    logic              disp_slot_s;
    logic              pat_sel_s;
    logic              rd_slot_s;
    logic              pat_slot_s;
    logic              c0_elig_s;
    logic              c1_elig_s;
    logic [31:0]       fetch_full_s;
    logic [DATA_W-1:0] pat_pix_s;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              c0_gnt_q, c0_gnt_d;
    logic              c1_gnt_q, c1_gnt_d;
    logic              last_c1_q, last_c1_d;
    logic [1:0]        rd_v_q, rd_v_d;
    logic [1:0]        is_pat_q, is_pat_d;
    logic [DATA_W-1:0] pat0_q, pat0_d;
    logic [DATA_W-1:0] pat1_q, pat1_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pixel_valid_q, pixel_valid_d;

    // Slot classification and framebuffer address of the upcoming screen block
    always_comb begin
`ifdef VGA_FB_TEST_PATTERN_EN
        pat_sel_s = bus.pattern_sel;
`else
        pat_sel_s = 1'b0;
`endif
        disp_slot_s  = bus.blank_n && (bus.nextX[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
        rd_slot_s    = disp_slot_s && !pat_sel_s;
        pat_slot_s   = disp_slot_s && pat_sel_s;
        // Masking with the current grant stops a client winning twice on a request it has not yet dropped.
        c0_elig_s    = bus.c0_req && !c0_gnt_q;
        c1_elig_s    = bus.c1_req && !c1_gnt_q;
        fetch_full_s = 32'(bus.nextY >> SCALE_LOG2) * 32'(FB_W) + 32'(bus.nextX >> SCALE_LOG2);
        pat_pix_s    = DATA_W'(bus.nextX >> 7);
    end

    // RAM port owner for this slot: display read, one writer, or idle
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        c0_gnt_d    = 1'b0;
        c1_gnt_d    = 1'b0;
        last_c1_d   = last_c1_q;
        if (rd_slot_s) begin
            mem_addr_d = ADDR_W'(fetch_full_s);
        end else if (c0_elig_s && (!c1_elig_s || last_c1_q)) begin
            mem_addr_d  = bus.c0_addr;
            mem_wdata_d = bus.c0_data;
            mem_we_d    = 1'b1;
            c0_gnt_d    = 1'b1;
            last_c1_d   = 1'b0;
        end else if (c1_elig_s) begin
            mem_addr_d  = bus.c1_addr;
            mem_wdata_d = bus.c1_data;
            mem_we_d    = 1'b1;
            c1_gnt_d    = 1'b1;
            last_c1_d   = 1'b1;
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // Two-stage tracking of display fetches; the last stage loads the scan-out pixel
    always_comb begin
        rd_v_d        = {rd_v_q[0], disp_slot_s};
        is_pat_d      = {is_pat_q[0], pat_slot_s};
        pat0_d        = pat_pix_s;
        pat1_d        = pat0_q;
        pixel_valid_d = rd_v_q[1];
        if (rd_v_q[1]) begin
            pixel_d = is_pat_q[1] ? pat1_q : bus.mem_rdata;
        end else begin
            pixel_d = pixel_q;
        end
    end

    // State registers; reset discards any fetch in flight and makes c0 win the first tie
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= {DATA_W{1'b0}};
            c0_gnt_q      <= 1'b0;
            c1_gnt_q      <= 1'b0;
            last_c1_q     <= 1'b1;
            rd_v_q        <= 2'b00;
            is_pat_q      <= 2'b00;
            pat0_q        <= {DATA_W{1'b0}};
            pat1_q        <= {DATA_W{1'b0}};
            pixel_q       <= {DATA_W{1'b0}};
            pixel_valid_q <= 1'b0;
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            c0_gnt_q      <= c0_gnt_d;
            c1_gnt_q      <= c1_gnt_d;
            last_c1_q     <= last_c1_d;
            rd_v_q        <= rd_v_d;
            is_pat_q      <= is_pat_d;
            pat0_q        <= pat0_d;
            pat1_q        <= pat1_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.c0_gnt      = c0_gnt_q;
    assign bus.c1_gnt      = c1_gnt_q;
    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;

endmodule
